// File: rtl/neuron_grid_pkg.sv
// Purpose: shared widths, CSRAM potential field location and host FSM states for the neuron grid host.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: grid geometry constants, CSRAM potential field bounds, host_state_e enum.
package neuron_grid_pkg;

  localparam int N_NEURON = 256;
  localparam int PARAM_W  = 368;
  localparam int POT_MSB  = 111;
  localparam int POT_LSB  = 103;
  localparam int POT_W    = 9;
  localparam int FRAME_W  = 256;
  localparam int ADDR_W   = 8;
  localparam int INS_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRM,
    GAP,
    TICK,
    RUN,
    EMIT
  } host_state_e;

endpackage

// File: rtl/spike_frame_fifo.sv
// Purpose: queue of axon-spike frames awaiting a grid tick.
// Latency: a pushed frame is visible at head_o the cycle after the push; head_o is read combinationally.
// Backpressure: full_o when DEPTH frames are held; a push is still taken when full if a pop occurs in the same cycle.
// Ports: clk/reset (sync, active-high), push_i/data_i write side, pop_i/head_o read side, full_o/empty_o status.
module spike_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // Storage is not reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/grid_host_controller.sv
// Purpose: host side of a neuron grid: CSRAM/instruction memories, spike-frame queue and per-tick run sequencing.
// Latency: memory reads are combinational; tick follows a queued frame by TICK_GAP+1 cycles; results register on done.
// Backpressure: frm_ready drops when the frame queue is full; out_valid holds result data until out_ready.
// Ports: config writes (cfg_*, ins_*), frame push (frm_*), run control (start/num_ticks/busy/err_*),
//        result handshake (out_*), grid-facing memory reads, tick/axon_spikes drive and grid status inputs.
module grid_host_controller
  import neuron_grid_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_GAP   = 3   // must be at least 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [PARAM_W-1:0] cfg_data,
  input  logic               ins_we,
  input  logic [ADDR_W-1:0]  ins_addr,
  input  logic [INS_W-1:0]   ins_data,
  input  logic               frm_valid,
  input  logic [FRAME_W-1:0] frm_data,
  output logic               frm_ready,
  input  logic               start,
  input  logic [7:0]         num_ticks,
  output logic               busy,
  output logic               err_grid,
  output logic               err_underflow,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_spikes,
  output logic [7:0]         out_tick,
  input  logic               out_ready,
  output logic [PARAM_W-1:0] neuron_parameter,
  output logic [INS_W-1:0]   neuron_instruction,
  output logic               tick,
  output logic [FRAME_W-1:0] axon_spikes,
  input  logic [7:0]         neuron_num,
  input  logic [7:0]         axon_num,
  input  logic               update_potential,
  input  logic [POT_W-1:0]   potential_out,
  input  logic               spike_out,
  input  logic               scheduler_set,
  input  logic               scheduler_clr,
  input  logic               done,
  input  logic               error
);

  localparam int GAP_W = (TICK_GAP > 1) ? $clog2(TICK_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TICK_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [PARAM_W-1:0] csram_q [N_NEURON];
  logic [INS_W-1:0]   imem_q  [N_NEURON];

  host_state_e        state_q;
  logic               busy_q;
  logic               tick_q;
  logic               out_valid_q;
  logic               err_grid_q;
  logic               err_underflow_q;
  logic [FRAME_W-1:0] axon_spikes_q;
  logic [FRAME_W-1:0] out_spikes_q;
  logic [7:0]         out_tick_q;
  logic [FRAME_W-1:0] acc_q;
  logic [FRAME_W-1:0] acc_d;
  logic [7:0]         tick_idx_q;
  logic [7:0]         tick_idx_inc;
  logic [7:0]         num_ticks_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               set_prev_q;
  logic               done_prev_q;
  logic               set_rise;
  logic               done_rise;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] fifo_head;

  // scheduler_clr is part of the grid interface but carries no host-side meaning.
  logic unused_sched_clr;
  assign unused_sched_clr = scheduler_clr;

  assign set_rise     = scheduler_set && !set_prev_q;
  assign done_rise    = done && !done_prev_q;
  assign tick_idx_inc = tick_idx_q + 8'd1;

  assign frm_ready = !fifo_full;
  assign fifo_push = frm_valid && frm_ready;
  assign fifo_pop  = (state_q == RUN) && set_rise && !fifo_empty;

  spike_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (frm_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign neuron_parameter   = csram_q[neuron_num];
  assign neuron_instruction = imem_q[axon_num];

  // Memories survive reset so a configured grid can be rerun after an abort.
  // The potential write comes second so it wins its field when both hit one row.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_q) begin
      csram_q[cfg_addr] <= cfg_data;
    end
    if (update_potential) begin
      csram_q[neuron_num][POT_MSB:POT_LSB] <= potential_out;
    end
    if (ins_we && !busy_q) begin
      imem_q[ins_addr] <= ins_data;
    end
  end

  // Include this cycle's spike so a spike coincident with done is not lost.
  always_comb begin
    acc_d = acc_q;
    if (update_potential && spike_out) begin
      acc_d[neuron_num] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      tick_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      err_grid_q      <= 1'b0;
      err_underflow_q <= 1'b0;
      axon_spikes_q   <= '0;
      out_spikes_q    <= '0;
      out_tick_q      <= '0;
      acc_q           <= '0;
      tick_idx_q      <= '0;
      num_ticks_q     <= '0;
      gap_cnt_q       <= '0;
      set_prev_q      <= 1'b0;
      done_prev_q     <= 1'b0;
    end else begin
      set_prev_q  <= scheduler_set;
      done_prev_q <= done;
      tick_q      <= 1'b0;
      if (error) begin
        err_grid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start && (num_ticks != 8'd0)) begin
            num_ticks_q <= num_ticks;
            tick_idx_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= WAIT_FRM;
          end
        end

        WAIT_FRM: begin
          if (!fifo_empty) begin
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            tick_q  <= 1'b1;
            state_q <= TICK;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_ONE;
          end
        end

        TICK: begin
          acc_q   <= '0;
          state_q <= RUN;
        end

        RUN: begin
          acc_q <= acc_d;
          if (set_rise) begin
            if (!fifo_empty) begin
              axon_spikes_q <= fifo_head;
            end else begin
              axon_spikes_q   <= '0;
              err_underflow_q <= 1'b1;
            end
          end
          if (done_rise) begin
            out_spikes_q <= acc_d;
            out_tick_q   <= tick_idx_q;
            out_valid_q  <= 1'b1;
            state_q      <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            tick_idx_q  <= tick_idx_inc;
            if (tick_idx_inc == num_ticks_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_FRM;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign tick          = tick_q;
  assign out_valid     = out_valid_q;
  assign err_grid      = err_grid_q;
  assign err_underflow = err_underflow_q;
  assign axon_spikes   = axon_spikes_q;
  assign out_spikes    = out_spikes_q;
  assign out_tick      = out_tick_q;

endmodule

// File: tb/tb_grid_host_controller.sv
// Purpose: self-checking bench for grid_host_controller with a transaction-level model of memories, frame queue and run.
// Latency: expects tick TICK_GAP+1 cycles after a run is ready with a frame queued; results the cycle after done.
// Backpressure: models frm_ready from queue occupancy and holds out_ready low to check result stability.
`timescale 1ns/1ps
module tb_grid_host_controller;
  import neuron_grid_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TICK_GAP   = 3;
  localparam int BUDGET     = 60;
  localparam logic [PARAM_W-1:0] POT_MASK = PARAM_W'({POT_W{1'b1}}) << POT_LSB;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [PARAM_W-1:0] cfg_data;
  logic               ins_we;
  logic [ADDR_W-1:0]  ins_addr;
  logic [INS_W-1:0]   ins_data;
  logic               frm_valid;
  logic [FRAME_W-1:0] frm_data;
  logic               frm_ready;
  logic               start;
  logic [7:0]         num_ticks;
  logic               busy;
  logic               err_grid;
  logic               err_underflow;
  logic               out_valid;
  logic [FRAME_W-1:0] out_spikes;
  logic [7:0]         out_tick;
  logic               out_ready;
  logic [PARAM_W-1:0] neuron_parameter;
  logic [INS_W-1:0]   neuron_instruction;
  logic               tick;
  logic [FRAME_W-1:0] axon_spikes;
  logic [7:0]         neuron_num;
  logic [7:0]         axon_num;
  logic               update_potential;
  logic [POT_W-1:0]   potential_out;
  logic               spike_out;
  logic               scheduler_set;
  logic               scheduler_clr;
  logic               done;
  logic               error;

  always #5 clk = ~clk;

  grid_host_controller #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TICK_GAP   (TICK_GAP)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_we             (cfg_we),
    .cfg_addr           (cfg_addr),
    .cfg_data           (cfg_data),
    .ins_we             (ins_we),
    .ins_addr           (ins_addr),
    .ins_data           (ins_data),
    .frm_valid          (frm_valid),
    .frm_data           (frm_data),
    .frm_ready          (frm_ready),
    .start              (start),
    .num_ticks          (num_ticks),
    .busy               (busy),
    .err_grid           (err_grid),
    .err_underflow      (err_underflow),
    .out_valid          (out_valid),
    .out_spikes         (out_spikes),
    .out_tick           (out_tick),
    .out_ready          (out_ready),
    .neuron_parameter   (neuron_parameter),
    .neuron_instruction (neuron_instruction),
    .tick               (tick),
    .axon_spikes        (axon_spikes),
    .neuron_num         (neuron_num),
    .axon_num           (axon_num),
    .update_potential   (update_potential),
    .potential_out      (potential_out),
    .spike_out          (spike_out),
    .scheduler_set      (scheduler_set),
    .scheduler_clr      (scheduler_clr),
    .done               (done),
    .error              (error)
  );

  // Reference model: memory images, frame queue and run bookkeeping.
  logic [PARAM_W-1:0] m_csram    [N_NEURON];
  bit                 m_csram_ok [N_NEURON];
  logic [INS_W-1:0]   m_imem     [N_NEURON];
  bit                 m_imem_ok  [N_NEURON];
  logic [FRAME_W-1:0] m_fifo [$];
  bit                 m_busy;
  int                 m_ticks;
  int                 m_idx;
  bit                 m_err_grid;
  bit                 m_err_uf;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [PARAM_W-1:0] obs, input logic [PARAM_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_W-1:0] rnd_frame();
    logic [FRAME_W-1:0] v;
    for (int i = 0; i < FRAME_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [PARAM_W-1:0] rnd_row();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v[PARAM_W-1:0];
  endfunction

  task automatic cfg_write(input int a, input logic [PARAM_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = d;
    step();
    cfg_we = 1'b0;
    if (!m_busy) begin
      m_csram[a] = d;
      m_csram_ok[a] = 1'b1;
    end
  endtask

  task automatic ins_write(input int a, input logic [INS_W-1:0] d);
    ins_we = 1'b1; ins_addr = 8'(a); ins_data = d;
    step();
    ins_we = 1'b0;
    if (!m_busy) begin
      m_imem[a] = d;
      m_imem_ok[a] = 1'b1;
    end
  endtask

  task automatic check_row(input int a);
    neuron_num = 8'(a);
    step();
    chk("csram_row", neuron_parameter, m_csram[a]);
  endtask

  task automatic check_ins(input int a);
    axon_num = 8'(a);
    step();
    chk("imem_word", PARAM_W'(neuron_instruction), PARAM_W'(m_imem[a]));
  endtask

  task automatic check_all_mem();
    for (int a = 0; a < N_NEURON; a++) begin
      if (m_csram_ok[a]) check_row(a);
      if (m_imem_ok[a]) check_ins(a);
    end
  endtask

  // Grid potential write-back; a spiking neuron is reported to the caller.
  task automatic pot_update(input int n, input logic [POT_W-1:0] p, input bit spk);
    update_potential = 1'b1; neuron_num = 8'(n); potential_out = p; spike_out = spk;
    step();
    update_potential = 1'b0; spike_out = 1'b0;
    m_csram[n] = (m_csram[n] & ~POT_MASK) | (PARAM_W'(p) << POT_LSB);
  endtask

  task automatic push_frame(input logic [FRAME_W-1:0] f);
    chk("frm_ready", PARAM_W'(frm_ready), PARAM_W'(m_fifo.size() < FIFO_DEPTH));
    frm_valid = 1'b1; frm_data = f;
    step();
    frm_valid = 1'b0;
    if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(f);
  endtask

  task automatic start_run(input int n);
    start = 1'b1; num_ticks = 8'(n);
    step();
    start = 1'b0;
    if (!m_busy && n != 0) begin
      m_busy = 1'b1; m_ticks = n; m_idx = 0;
    end
    chk("busy_after_start", PARAM_W'(busy), PARAM_W'(m_busy));
  endtask

  task automatic wait_tick();
    int cnt;
    cnt = 0;
    while (tick !== 1'b1 && cnt < BUDGET) begin
      step();
      cnt++;
    end
    chk("tick_delay", PARAM_W'(cnt), PARAM_W'(TICK_GAP + 1));
    step();
    chk("tick_width", PARAM_W'(tick), '0);
  endtask

  // One full grid tick: wait for tick, scheduler pulses, spikes, done, result handshake.
  task automatic run_tick(input int pulses, input logic [FRAME_W-1:0] must_spike, input int n_rand, input int hold);
    logic [FRAME_W-1:0] acc;
    logic [FRAME_W-1:0] exp_ax;
    int n;
    bit s;
    wait_tick();
    acc = '0;
    for (int p = 0; p < pulses; p++) begin
      scheduler_set = 1'b1;
      step();
      scheduler_set = 1'b0;
      if (m_fifo.size() > 0) exp_ax = m_fifo.pop_front();
      else begin
        exp_ax = '0;
        m_err_uf = 1'b1;
      end
      chk("axon_spikes", PARAM_W'(axon_spikes), PARAM_W'(exp_ax));
      chk("err_underflow", PARAM_W'(err_underflow), PARAM_W'(m_err_uf));
      chk("frm_ready_after_pop", PARAM_W'(frm_ready), PARAM_W'(m_fifo.size() < FIFO_DEPTH));
      step();
    end
    for (int i = 0; i < N_NEURON; i++) begin
      if (must_spike[i]) begin
        pot_update(i, 9'($urandom), 1'b1);
        acc[i] = 1'b1;
      end
    end
    for (int k = 0; k < n_rand; k++) begin
      n = $urandom_range(0, N_NEURON - 1);
      s = 1'($urandom_range(0, 1));
      scheduler_clr = 1'($urandom_range(0, 1));
      pot_update(n, 9'($urandom), s);
      if (s) acc[n] = 1'b1;
    end
    scheduler_clr = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("out_valid", PARAM_W'(out_valid), PARAM_W'(1));
    chk("out_spikes", PARAM_W'(out_spikes), PARAM_W'(acc));
    chk("out_tick", PARAM_W'(out_tick), PARAM_W'(m_idx));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_out_valid", PARAM_W'(out_valid), PARAM_W'(1));
      chk("hold_out_spikes", PARAM_W'(out_spikes), PARAM_W'(acc));
      chk("hold_no_tick", PARAM_W'(tick), '0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    m_idx++;
    if (m_idx == m_ticks) m_busy = 1'b0;
    chk("out_valid_after_hs", PARAM_W'(out_valid), '0);
    chk("busy_after_hs", PARAM_W'(busy), PARAM_W'(m_busy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PARAM_W-1:0] row;
    logic [FRAME_W-1:0] must;
    int nt;
    int a;

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    ins_we = 1'b0; ins_addr = '0; ins_data = '0; frm_valid = 1'b0; frm_data = '0;
    start = 1'b0; num_ticks = '0; out_ready = 1'b0; neuron_num = '0; axon_num = '0;
    update_potential = 1'b0; potential_out = '0; spike_out = 1'b0;
    scheduler_set = 1'b0; scheduler_clr = 1'b0; done = 1'b0; error = 1'b0;
    m_busy = 1'b0; m_ticks = 0; m_idx = 0; m_err_grid = 1'b0; m_err_uf = 1'b0;
    for (int i = 0; i < N_NEURON; i++) begin
      m_csram_ok[i] = 1'b0;
      m_imem_ok[i] = 1'b0;
    end

    // Reset state.
    repeat (3) step();
    reset = 1'b0;
    chk("rst_busy", PARAM_W'(busy), '0);
    chk("rst_tick", PARAM_W'(tick), '0);
    chk("rst_out_valid", PARAM_W'(out_valid), '0);
    chk("rst_err_grid", PARAM_W'(err_grid), '0);
    chk("rst_err_underflow", PARAM_W'(err_underflow), '0);
    chk("rst_axon_spikes", PARAM_W'(axon_spikes), '0);
    chk("rst_out_spikes", PARAM_W'(out_spikes), '0);
    chk("rst_out_tick", PARAM_W'(out_tick), '0);
    chk("rst_frm_ready", PARAM_W'(frm_ready), PARAM_W'(1));
    step();

    // Configuration memories with random content; row 5 has a zero potential field.
    cfg_write(5, rnd_row() & ~POT_MASK);
    cfg_write(0, rnd_row());
    cfg_write(255, rnd_row());
    for (int i = 0; i < 5; i++) cfg_write($urandom_range(1, 254), rnd_row());
    for (int i = 0; i < 10; i++) ins_write($urandom_range(0, N_NEURON - 1), 2'($urandom));
    check_all_mem();

    // Potential write-back into row 5, then a few random rows.
    row = m_csram[5];
    pot_update(5, 9'h1A3, 1'b0);
    neuron_num = 8'd5;
    #1;
    chk("pot_row5", neuron_parameter, (row & ~POT_MASK) | (PARAM_W'(9'h1A3) << POT_LSB));
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, N_NEURON - 1);
      if (!m_csram_ok[a]) cfg_write(a, rnd_row());
      pot_update(a, 9'($urandom), 1'b0);
      check_row(a);
    end

    // Start with zero ticks is ignored.
    start_run(0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("zero_ticks_no_tick", PARAM_W'(tick), '0);
    end

    // Two-tick run; neurons 0 and 255 spike in tick 0, result held 10 cycles.
    push_frame(rnd_frame());
    push_frame(rnd_frame());
    start_run(2);
    must = '0;
    must[0] = 1'b1;
    must[N_NEURON-1] = 1'b1;
    run_tick(1, must, 3, 10);
    run_tick(1, '0, 4, 2);

    // Run stalls on empty queue; writes and start while busy are ignored.
    start_run(1);
    cfg_write(0, rnd_row());
    ins_write(7, 2'($urandom));
    start_run(5);
    error = 1'b1;
    step();
    error = 1'b0;
    m_err_grid = 1'b1;
    chk("err_grid_set", PARAM_W'(err_grid), PARAM_W'(m_err_grid));
    for (int i = 0; i < 12; i++) begin
      step();
      chk("stall_no_tick", PARAM_W'(tick), '0);
    end
    push_frame(rnd_frame());
    run_tick(1, '0, 2, 0);
    chk("err_grid_sticky", PARAM_W'(err_grid), PARAM_W'(m_err_grid));
    check_row(0);
    if (m_imem_ok[7]) check_ins(7);

    // Fill the queue, then drain it one frame per tick; the last tick underflows.
    for (int i = 0; i < FIFO_DEPTH; i++) push_frame(rnd_frame());
    chk("frm_ready_full", PARAM_W'(frm_ready), '0);
    push_frame(rnd_frame());
    start_run(FIFO_DEPTH);
    for (int t = 0; t < FIFO_DEPTH; t++) run_tick((t == FIFO_DEPTH - 1) ? 2 : 1, '0, 2, 1);
    chk("underflow_sticky", PARAM_W'(err_underflow), PARAM_W'(m_err_uf));

    // Randomised runs.
    for (int r = 0; r < 3; r++) begin
      nt = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < nt; i++) push_frame(rnd_frame());
      start_run(nt);
      for (int t = 0; t < nt; t++) run_tick(1, '0, $urandom_range(1, 6), $urandom_range(0, 3));
      chk("busy_idle_after_run", PARAM_W'(busy), '0);
    end

    // Reset in the middle of a run.
    push_frame(rnd_frame());
    push_frame(rnd_frame());
    start_run(1);
    wait_tick();
    scheduler_set = 1'b1;
    step();
    scheduler_set = 1'b0;
    chk("pre_reset_axon", PARAM_W'(axon_spikes), PARAM_W'(m_fifo.pop_front()));
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_fifo.delete();
    m_busy = 1'b0; m_err_grid = 1'b0; m_err_uf = 1'b0;
    chk("midrst_busy", PARAM_W'(busy), '0);
    chk("midrst_tick", PARAM_W'(tick), '0);
    chk("midrst_out_valid", PARAM_W'(out_valid), '0);
    chk("midrst_axon", PARAM_W'(axon_spikes), '0);
    chk("midrst_err_grid", PARAM_W'(err_grid), PARAM_W'(m_err_grid));
    chk("midrst_err_underflow", PARAM_W'(err_underflow), PARAM_W'(m_err_uf));
    done = 1'b1;
    step();
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_out_valid", PARAM_W'(out_valid), '0);
      step();
    end
    for (int i = 0; i < FIFO_DEPTH; i++) push_frame(rnd_frame());
    chk("midrst_fifo_was_empty", PARAM_W'(frm_ready), '0);
    check_all_mem();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
